// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back slice.
// Register-file geometry comes from the width macros; defaults apply when no build defines them.
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package wb_pkg;

    localparam int REG_NUM          = `REG_NUM;
    localparam int REG_WIDTH        = `REG_WIDTH;
    localparam int DATA_WIDTH       = `DATA_WIDTH;
    localparam int WB_DEPTH_DEFAULT = 2;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic logic [REG_NUM-1:0] rd_onehot(input logic [REG_WIDTH-1:0] rd);
        logic [REG_NUM-1:0] vec;
        vec     = '0;
        vec[rd] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-channel result buffer: a small circular FIFO that also reports which
// destination registers its occupied slots target.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_valid,
    output logic               push_ready,
    input  wb_entry_t          push_entry,
    output logic               head_valid,
    output wb_entry_t          head_entry,
    input  logic               pop,
    output logic [REG_NUM-1:0] pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready looks only at the registered count, so a full buffer stays closed even while popping.
    assign push_ready = !rst && (count_q < CNT_W'(DEPTH));
    assign head_valid = (count_q != '0);
    assign head_entry = mem_q[rd_ptr_q];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && head_valid;

    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending = pending | rd_onehot(mem_q[i].rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back unit: buffers ALU and LSU results, round-robins them onto the single
// register-file write port and publishes which destinations are still in flight.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_WIDTH-1:0]  alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_WIDTH-1:0]  lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rw_en,
    output logic [REG_WIDTH-1:0]  rw_addr,
    output logic [DATA_WIDTH-1:0] rw_data,
    output logic [REG_NUM-1:0]    pending
);

    wb_entry_t            alu_entry, lsu_entry;
    wb_entry_t            alu_head, lsu_head;
    logic                 alu_head_valid, lsu_head_valid;
    logic                 alu_pop, lsu_pop;
    logic [REG_NUM-1:0]   alu_pending, lsu_pending;

    wb_src_e              last_grant_q, last_grant_d;
    logic                 rw_en_q, rw_en_d;
    logic [REG_WIDTH-1:0] rw_addr_q, rw_addr_d;
    logic [DATA_WIDTH-1:0] rw_data_q, rw_data_d;

    assign alu_entry = '{rd: alu_rd, data: alu_data};
    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

    // Writes to r0 complete the handshake but are never stored.
    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (alu_valid && (alu_rd != '0)),
        .push_ready (alu_ready),
        .push_entry (alu_entry),
        .head_valid (alu_head_valid),
        .head_entry (alu_head),
        .pop        (alu_pop),
        .pending    (alu_pending)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (lsu_valid && (lsu_rd != '0)),
        .push_ready (lsu_ready),
        .push_entry (lsu_entry),
        .head_valid (lsu_head_valid),
        .head_entry (lsu_head),
        .pop        (lsu_pop),
        .pending    (lsu_pending)
    );

    // On a tie the channel that did not win last time is served.
    always_comb begin
        alu_pop      = 1'b0;
        lsu_pop      = 1'b0;
        last_grant_d = last_grant_q;
        rw_en_d      = 1'b0;
        rw_addr_d    = '0;
        rw_data_d    = '0;
        if (alu_head_valid && lsu_head_valid) begin
            if (last_grant_q == WB_ALU) begin
                lsu_pop = 1'b1;
            end else begin
                alu_pop = 1'b1;
            end
        end else begin
            alu_pop = alu_head_valid;
            lsu_pop = lsu_head_valid;
        end
        if (alu_pop) begin
            last_grant_d = WB_ALU;
            rw_en_d      = 1'b1;
            rw_addr_d    = alu_head.rd;
            rw_data_d    = alu_head.data;
        end else if (lsu_pop) begin
            last_grant_d = WB_LSU;
            rw_en_d      = 1'b1;
            rw_addr_d    = lsu_head.rd;
            rw_data_d    = lsu_head.data;
        end
    end

    always_comb begin
        pending    = alu_pending | lsu_pending | (rw_en_q ? rd_onehot(rw_addr_q) : '0);
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= WB_ALU;
            rw_en_q      <= 1'b0;
            rw_addr_q    <= '0;
            rw_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rw_en_q      <= rw_en_d;
            rw_addr_q    <= rw_addr_d;
            rw_data_q    <= rw_data_d;
        end
    end

    assign rw_en   = rw_en_q;
    assign rw_addr = rw_addr_q;
    assign rw_data = rw_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus a randomized
// run scored against per-channel queues of accepted-but-unwritten results.
module tb_regfile_writeback;
    import wb_pkg::*;

    localparam int DEPTH = 2;

    typedef enum int {SRC_NONE, SRC_ALU, SRC_LSU, SRC_BAD} src_e;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [REG_WIDTH-1:0]  alu_rd, lsu_rd, rw_addr;
    logic [DATA_WIDTH-1:0] alu_data, lsu_data, rw_data;
    logic                  rw_en;
    logic [REG_NUM-1:0]    pending;

    int n_compared   = 0;
    int n_mismatched = 0;

    wb_entry_t             exp_alu[$];
    wb_entry_t             exp_lsu[$];
    logic [REG_WIDTH-1:0]  wr_log[$];
    logic [REG_NUM-1:0]    model_pending;
    logic                  obs_en;
    logic [REG_WIDTH-1:0]  obs_addr;
    logic [DATA_WIDTH-1:0] obs_data;
    logic [REG_NUM-1:0]    obs_pending;
    logic                  obs_alu_ready, obs_lsu_ready;
    logic                  last_alu_acc, last_lsu_acc;
    int                    alu_cnt_before, lsu_cnt_before;
    src_e                  wr_src;
    int                    exp_order[6] = '{4, 1, 5, 2, 6, 3};

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rw_en     (rw_en),
        .rw_addr   (rw_addr),
        .rw_data   (rw_data),
        .pending   (pending)
    );

    // One clock of stimulus; afterwards the model reflects the new cycle and the
    // observed write (if any) is matched against the head of either channel queue.
    task automatic apply_cycle(input logic r,
                               input logic av, input logic [REG_WIDTH-1:0] ard, input logic [DATA_WIDTH-1:0] adat,
                               input logic lv, input logic [REG_WIDTH-1:0] lrd, input logic [DATA_WIDTH-1:0] ldat);
        wb_entry_t e;
        rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
        #1;
        obs_alu_ready  = alu_ready;
        obs_lsu_ready  = lsu_ready;
        last_alu_acc   = av && alu_ready;
        last_lsu_acc   = lv && lsu_ready;
        alu_cnt_before = exp_alu.size();
        lsu_cnt_before = exp_lsu.size();
        @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0; rst = 1'b0;
        if (r) begin
            exp_alu.delete();
            exp_lsu.delete();
        end else begin
            if (last_alu_acc && ard != '0) begin e.rd = ard; e.data = adat; exp_alu.push_back(e); end
            if (last_lsu_acc && lrd != '0) begin e.rd = lrd; e.data = ldat; exp_lsu.push_back(e); end
        end
        model_pending = '0;
        foreach (exp_alu[i]) model_pending[exp_alu[i].rd] = 1'b1;
        foreach (exp_lsu[i]) model_pending[exp_lsu[i].rd] = 1'b1;
        obs_en = rw_en; obs_addr = rw_addr; obs_data = rw_data; obs_pending = pending;
        wr_src = SRC_NONE;
        if (rw_en) begin
            if (exp_alu.size() > 0 && exp_alu[0].rd == rw_addr && exp_alu[0].data == rw_data) begin
                wr_src = SRC_ALU;
                void'(exp_alu.pop_front());
            end else if (exp_lsu.size() > 0 && exp_lsu[0].rd == rw_addr && exp_lsu[0].data == rw_data) begin
                wr_src = SRC_LSU;
                void'(exp_lsu.pop_front());
            end else begin
                wr_src = SRC_BAD;
            end
            wr_log.push_back(rw_addr);
        end
    endtask

    task automatic idle();
        apply_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    function automatic logic [REG_WIDTH-1:0] pick_rd(input logic [REG_NUM-1:0] busy, input logic [REG_WIDTH-1:0] avoid);
        logic [REG_WIDTH-1:0] r;
        if ($urandom_range(7) == 0) return '0;
        for (int t = 0; t < 64; t++) begin
            r = REG_WIDTH'($urandom_range(REG_NUM - 1, 1));
            if (!busy[r] && r != avoid) return r;
        end
        return '0;
    endfunction

    task automatic test_reset();
        apply_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        n_compared++; if (obs_alu_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_alu_ready: got %b expected 0", obs_alu_ready); end
        n_compared++; if (obs_lsu_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_lsu_ready: got %b expected 0", obs_lsu_ready); end
        n_compared++; if (obs_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rw_en: got %b expected 0", obs_en); end
        n_compared++; if (obs_addr !== '0) begin n_mismatched++; $display("[TB] FAIL reset_rw_addr: got %0d expected 0", obs_addr); end
        n_compared++; if (obs_data !== '0) begin n_mismatched++; $display("[TB] FAIL reset_rw_data: got %h expected 0", obs_data); end
        n_compared++; if (obs_pending !== '0) begin n_mismatched++; $display("[TB] FAIL reset_pending: got %h expected 0", obs_pending); end
        idle();
        n_compared++; if (obs_alu_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_alu_ready: got %b expected 1", obs_alu_ready); end
        n_compared++; if (obs_lsu_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_lsu_ready: got %b expected 1", obs_lsu_ready); end
    endtask

    task automatic test_single_alu();
        apply_cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        n_compared++; if (last_alu_acc !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_accept: got %b expected 1", last_alu_acc); end
        n_compared++; if (obs_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_c0_rw_en: got %b expected 0", obs_en); end
        n_compared++; if (obs_pending !== 32'h0000_0020) begin n_mismatched++; $display("[TB] FAIL single_c0_pending: got %h expected 00000020", obs_pending); end
        idle();
        n_compared++; if (obs_en !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_c1_rw_en: got %b expected 1", obs_en); end
        n_compared++; if (obs_addr !== 5'd5) begin n_mismatched++; $display("[TB] FAIL single_c1_rw_addr: got %0d expected 5", obs_addr); end
        n_compared++; if (obs_data !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL single_c1_rw_data: got %h expected deadbeef", obs_data); end
        n_compared++; if (obs_pending[5] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_c1_pending5: got %b expected 1", obs_pending[5]); end
        n_compared++; if (wr_src !== SRC_ALU) begin n_mismatched++; $display("[TB] FAIL single_c1_source: got %0d expected %0d", wr_src, SRC_ALU); end
        idle();
        n_compared++; if (obs_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_c2_rw_en: got %b expected 0", obs_en); end
        n_compared++; if (obs_pending !== '0) begin n_mismatched++; $display("[TB] FAIL single_c2_pending: got %h expected 0", obs_pending); end
    endtask

    task automatic test_contention();
        int  ai = 0, li = 0;
        bit  saw_alu_block = 1'b0;
        logic a_off, l_off;
        apply_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        wr_log.delete();
        for (int c = 0; c < 20; c++) begin
            a_off = (ai < 3);
            l_off = (li < 3);
            apply_cycle(1'b0, a_off, REG_WIDTH'(ai + 1), 32'hA000_0000 + 32'(ai),
                        l_off, REG_WIDTH'(li + 4), 32'hB000_0000 + 32'(li));
            if (a_off && !obs_alu_ready) saw_alu_block = 1'b1;
            if (last_alu_acc) ai++;
            if (last_lsu_acc) li++;
            n_compared++; if (obs_pending !== model_pending) begin n_mismatched++; $display("[TB] FAIL contention_pending: got %h expected %h", obs_pending, model_pending); end
            n_compared++; if (wr_src == SRC_BAD) begin n_mismatched++; $display("[TB] FAIL contention_write: got rd %0d data %h expected a queued head", obs_addr, obs_data); end
        end
        n_compared++; if (wr_log.size() !== 6) begin n_mismatched++; $display("[TB] FAIL contention_count: got %0d expected 6", wr_log.size()); end
        for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
            n_compared++; if (int'(wr_log[i]) !== exp_order[i]) begin n_mismatched++; $display("[TB] FAIL contention_order[%0d]: got %0d expected %0d", i, wr_log[i], exp_order[i]); end
        end
        n_compared++; if (saw_alu_block !== 1'b1) begin n_mismatched++; $display("[TB] FAIL contention_alu_ready_drop: got %b expected 1", saw_alu_block); end
    endtask

    task automatic test_backpressure();
        int li = 0;
        wr_log.delete();
        for (int c = 0; c < 12; c++) begin
            apply_cycle(1'b0, 1'b0, '0, '0, li < 4, REG_WIDTH'(li + 7), 32'hC000_0000 + 32'(li));
            if (last_lsu_acc) li++;
            n_compared++; if (obs_lsu_ready !== (lsu_cnt_before < DEPTH)) begin n_mismatched++; $display("[TB] FAIL bp_lsu_ready: got %b expected %b", obs_lsu_ready, lsu_cnt_before < DEPTH); end
            n_compared++; if (obs_pending !== model_pending) begin n_mismatched++; $display("[TB] FAIL bp_pending: got %h expected %h", obs_pending, model_pending); end
        end
        n_compared++; if (wr_log.size() !== 4) begin n_mismatched++; $display("[TB] FAIL bp_count: got %0d expected 4", wr_log.size()); end
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            n_compared++; if (int'(wr_log[i]) !== i + 7) begin n_mismatched++; $display("[TB] FAIL bp_order[%0d]: got %0d expected %0d", i, wr_log[i], i + 7); end
        end
    endtask

    task automatic test_rd_zero();
        apply_cycle(1'b0, 1'b1, '0, 32'h0000_1234, 1'b0, '0, '0);
        n_compared++; if (last_alu_acc !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd0_handshake: got %b expected 1", last_alu_acc); end
        for (int c = 0; c < 3; c++) begin
            n_compared++; if (obs_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rd0_rw_en: got %b expected 0", obs_en); end
            n_compared++; if (obs_pending !== '0) begin n_mismatched++; $display("[TB] FAIL rd0_pending: got %h expected 0", obs_pending); end
            idle();
        end
    endtask

    task automatic test_reset_midflight();
        apply_cycle(1'b0, 1'b1, 5'd13, 32'h1313_1313, 1'b1, 5'd14, 32'h1414_1414);
        apply_cycle(1'b0, 1'b1, 5'd15, 32'h1515_1515, 1'b1, 5'd16, 32'h1616_1616);
        apply_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        n_compared++; if (obs_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_rw_en: got %b expected 0", obs_en); end
        n_compared++; if (obs_addr !== '0) begin n_mismatched++; $display("[TB] FAIL midrst_rw_addr: got %0d expected 0", obs_addr); end
        n_compared++; if (obs_pending !== '0) begin n_mismatched++; $display("[TB] FAIL midrst_pending: got %h expected 0", obs_pending); end
        for (int c = 0; c < 4; c++) begin
            idle();
            n_compared++; if (obs_en !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_stale_write: got rd %0d expected no write", obs_addr); end
        end
        apply_cycle(1'b0, 1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd21, 32'h2121_2121);
        idle();
        n_compared++; if (obs_addr !== 5'd21 || wr_src !== SRC_LSU) begin n_mismatched++; $display("[TB] FAIL midrst_first_tie: got rd %0d src %0d expected rd 21 src %0d", obs_addr, wr_src, SRC_LSU); end
        idle();
        n_compared++; if (obs_addr !== 5'd20 || wr_src !== SRC_ALU) begin n_mismatched++; $display("[TB] FAIL midrst_second_tie: got rd %0d src %0d expected rd 20 src %0d", obs_addr, wr_src, SRC_ALU); end
        idle();
    endtask

    task automatic test_wrap_stress();
        logic                  av, lv;
        logic [REG_WIDTH-1:0]  ar, lr;
        for (int c = 0; c < 100; c++) begin
            av = ($urandom_range(3) != 0);
            lv = ($urandom_range(3) != 0);
            ar = pick_rd(model_pending, '0);
            lr = pick_rd(model_pending, ar);
            assert (!(av && ar != '0 && model_pending[ar]) && !(lv && lr != '0 && model_pending[lr]));
            apply_cycle(1'b0, av, ar, DATA_WIDTH'($urandom), lv, lr, DATA_WIDTH'($urandom));
            n_compared++; if (obs_pending !== model_pending) begin n_mismatched++; $display("[TB] FAIL stress_pending: got %h expected %h", obs_pending, model_pending); end
            n_compared++; if (wr_src == SRC_BAD) begin n_mismatched++; $display("[TB] FAIL stress_write: got rd %0d data %h expected a queued head", obs_addr, obs_data); end
            n_compared++; if (obs_alu_ready !== (alu_cnt_before < DEPTH)) begin n_mismatched++; $display("[TB] FAIL stress_alu_ready: got %b expected %b", obs_alu_ready, alu_cnt_before < DEPTH); end
            n_compared++; if (obs_lsu_ready !== (lsu_cnt_before < DEPTH)) begin n_mismatched++; $display("[TB] FAIL stress_lsu_ready: got %b expected %b", obs_lsu_ready, lsu_cnt_before < DEPTH); end
        end
        for (int c = 0; c < 20 && (exp_alu.size() + exp_lsu.size()) > 0; c++) begin
            idle();
            n_compared++; if (wr_src == SRC_BAD) begin n_mismatched++; $display("[TB] FAIL drain_write: got rd %0d data %h expected a queued head", obs_addr, obs_data); end
        end
        n_compared++; if (exp_alu.size() + exp_lsu.size() !== 0) begin n_mismatched++; $display("[TB] FAIL drain_leftover: got %0d unwritten expected 0", exp_alu.size() + exp_lsu.size()); end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
        @(negedge clk);
        test_reset();
        test_single_alu();
        test_contention();
        test_backpressure();
        test_rd_zero();
        test_reset_midflight();
        test_wrap_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
